// File: rtl/wb_stage.sv
// wb_stage: writeback stage feeding a register file that has no write enable.
// Every cycle without a write drives o_rd = 0 and o_rd_data = 0, so r0 stays zero.
// Loads wait for variable-latency read data. The data is then byte-aligned and
// sign- or zero-extended before it is written back.
// Optional macro WB_FWD_EN adds combinational forwarding outputs o_fwd_*.
module wb_stage #(
   parameter int DATA_W = 32,
   parameter int RD_W   = 5
) (
   input  logic              i_clk,
   input  logic              i_rst,
   input  logic              i_valid,
   output logic              o_ready,
   input  logic              i_wb_en,
   input  logic [RD_W-1:0]   i_rd,
   input  logic [DATA_W-1:0] i_alu_result,
   input  logic              i_is_load,
   input  logic [2:0]        i_load_type,
   input  logic [1:0]        i_addr_lo,
   input  logic              i_flush,
   input  logic              i_dmem_rvalid,
   input  logic [DATA_W-1:0] i_dmem_rdata,
   output logic [RD_W-1:0]   o_rd,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_retire,
   output logic              o_addr_err
`ifdef WB_FWD_EN
   ,
   output logic              o_fwd_valid,
   output logic [RD_W-1:0]   o_fwd_rd,
   output logic [DATA_W-1:0] o_fwd_data
`endif
);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      WAIT_LOAD = 2'd1,
      DRAIN     = 2'd2
   } state_t;

   state_t state;
   state_t state_nxt;

   // Load context captured when a load is accepted
   logic [RD_W-1:0] rd_p0;
   logic            wb_en_p0;
   logic [2:0]      ltype_p0;
   logic [1:0]      lo_p0;
   logic            misalign_p0;

   // Values to be registered into the outputs on the next edge
   logic [RD_W-1:0]   rd_nxt;
   logic [DATA_W-1:0] data_nxt;
   logic              retire_nxt;
   logic              err_nxt;

   logic accept;

   // Pick the addressed byte or halfword and extend it to the full width
   function automatic logic [DATA_W-1:0] align_load(input logic [DATA_W-1:0] word,
                                                     input logic [2:0]        ltype,
                                                     input logic [1:0]        lo);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lo, 3'b000} +: 8];
      h = lo[1] ? word[31:16] : word[15:0];
      case (ltype)
         3'b001:  align_load = {{(DATA_W-16){h[15]}}, h};
         3'b010:  align_load = {{(DATA_W-16){1'b0}}, h};
         3'b011:  align_load = {{(DATA_W-8){b[7]}}, b};
         3'b100:  align_load = {{(DATA_W-8){1'b0}}, b};
         default: align_load = word;
      endcase
   endfunction

   // Words must be word-aligned and halves half-aligned; bytes are always aligned
   function automatic logic is_misaligned(input logic [2:0] ltype, input logic [1:0] lo);
      case (ltype)
         3'b001, 3'b010: is_misaligned = lo[0];
         3'b011, 3'b100: is_misaligned = 1'b0;
         default:        is_misaligned = (lo != 2'b00);
      endcase
   endfunction

   assign o_ready = (state == IDLE);
   // A flush in IDLE squashes the presented instruction
   assign accept  = i_valid & o_ready & ~i_flush;

   // State register
   always_ff @(posedge i_clk) begin
      if (i_rst) state <= IDLE;
      else       state <= state_nxt;
   end

   // Next-state logic
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:      if (accept && i_is_load) state_nxt = WAIT_LOAD;
         WAIT_LOAD: begin
            if (i_dmem_rvalid)  state_nxt = IDLE;
            else if (i_flush)   state_nxt = DRAIN;
         end
         DRAIN:     if (i_dmem_rvalid) state_nxt = IDLE;
         default:   state_nxt = IDLE;
      endcase
   end

   // Output decode: the write, retire and error values for the next cycle
   always_comb begin
      rd_nxt     = '0;
      data_nxt   = '0;
      retire_nxt = 1'b0;
      err_nxt    = 1'b0;
      if (!i_rst) begin
         case (state)
            IDLE: begin
               if (accept && !i_is_load) begin
                  retire_nxt = 1'b1;
                  if (i_wb_en && (i_rd != '0)) begin
                     rd_nxt   = i_rd;
                     data_nxt = i_alu_result;
                  end
               end
            end
            WAIT_LOAD: begin
               if (i_dmem_rvalid && !i_flush) begin
                  retire_nxt = 1'b1;
                  if (misalign_p0) begin
                     err_nxt = 1'b1;
                  end else if (wb_en_p0 && (rd_p0 != '0)) begin
                     rd_nxt   = rd_p0;
                     data_nxt = align_load(i_dmem_rdata, ltype_p0, lo_p0);
                  end
               end
            end
            default: ;
         endcase
      end
   end

   // Capture load context on acceptance; only read while waiting for data
   always_ff @(posedge i_clk) begin
      if (accept && i_is_load) begin
         rd_p0       <= i_rd;
         wb_en_p0    <= i_wb_en;
         ltype_p0    <= i_load_type;
         lo_p0       <= i_addr_lo;
         misalign_p0 <= is_misaligned(i_load_type, i_addr_lo);
      end
   end

   // Registered outputs; each write lasts one cycle and then returns to zero
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         o_rd       <= '0;
         o_rd_data  <= '0;
         o_retire   <= 1'b0;
         o_addr_err <= 1'b0;
      end else begin
         o_rd       <= rd_nxt;
         o_rd_data  <= data_nxt;
         o_retire   <= retire_nxt;
         o_addr_err <= err_nxt;
      end
   end

`ifdef WB_FWD_EN
   // Early view of the write being registered this cycle, for decode bypass
   assign o_fwd_valid = (rd_nxt != '0);
   assign o_fwd_rd    = rd_nxt;
   assign o_fwd_data  = data_nxt;
`endif

endmodule

// File: tb/tb_wb_stage.sv
// tb_wb_stage: directed and randomized checks of wb_stage against a behavioural model.
// The forwarding outputs are checked when WB_FWD_EN is defined.
module tb_wb_stage;

   logic        clk = 1'b0;
   logic        rst, valid, wb_en, is_load, flush, rvalid;
   logic [4:0]  rd;
   logic [31:0] alu, rdata;
   logic [2:0]  ltype;
   logic [1:0]  lo;
   logic        ready, retire, addr_err;
   logic [4:0]  o_rd;
   logic [31:0] o_data;
`ifdef WB_FWD_EN
   logic        fwd_valid;
   logic [4:0]  fwd_rd;
   logic [31:0] fwd_data;
`endif

   int n_tests = 0;
   int n_fail  = 0;

   // Model state: 0 idle, 1 awaiting load data, 2 discarding data after a flush
   int          busy = 0;
   logic [4:0]  p_rd;
   logic        p_wb;
   logic [2:0]  p_type;
   logic [1:0]  p_lo;

   always #5 clk = ~clk;

   wb_stage #(.DATA_W(32), .RD_W(5)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(ready),
      .i_wb_en(wb_en), .i_rd(rd), .i_alu_result(alu), .i_is_load(is_load),
      .i_load_type(ltype), .i_addr_lo(lo), .i_flush(flush),
      .i_dmem_rvalid(rvalid), .i_dmem_rdata(rdata),
      .o_rd(o_rd), .o_rd_data(o_data), .o_retire(retire), .o_addr_err(addr_err)
`ifdef WB_FWD_EN
      , .o_fwd_valid(fwd_valid), .o_fwd_rd(fwd_rd), .o_fwd_data(fwd_data)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Reference load result from the little-endian lane rules
   function automatic logic [31:0] ref_load(input logic [31:0] w, input logic [2:0] t,
                                            input logic [1:0] a);
      int unsigned b, h;
      b = (w >> (8 * a)) & 32'hFF;
      h = (w >> (16 * a[1])) & 32'hFFFF;
      case (t)
         3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
         3'd2:    return h;
         3'd3:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
         3'd4:    return b;
         default: return w;
      endcase
   endfunction

   function automatic bit ref_misaligned(input logic [2:0] t, input logic [1:0] a);
      if (t == 3'd1 || t == 3'd2) return (a % 2) != 0;
      if (t == 3'd3 || t == 3'd4) return 1'b0;
      return a != 0;
   endfunction

   task automatic idle_in();
      rst = 0; valid = 0; wb_en = 0; is_load = 0; flush = 0; rvalid = 0;
      rd = 0; alu = 0; rdata = 0; ltype = 0; lo = 0;
   endtask

   // Apply the current inputs for one cycle, then check the DUT against the model
   task automatic step();
      logic [4:0]  e_rd;
      logic [31:0] e_data;
      logic        e_ret, e_err;
      int          nb;
      e_rd = 0; e_data = 0; e_ret = 0; e_err = 0; nb = busy;
      #1;
      chk("ready", ready, busy == 0);
      if (rst) begin
         nb = 0;
      end else if (busy == 0) begin
         if (valid && !flush) begin
            if (!is_load) begin
               e_ret = 1;
               if (wb_en && rd != 0) begin e_rd = rd; e_data = alu; end
            end else begin
               nb = 1; p_rd = rd; p_wb = wb_en; p_type = ltype; p_lo = lo;
            end
         end
      end else if (busy == 1) begin
         if (rvalid) begin
            nb = 0;
            if (!flush) begin
               e_ret = 1;
               if (ref_misaligned(p_type, p_lo)) e_err = 1;
               else if (p_wb && p_rd != 0) begin
                  e_rd = p_rd; e_data = ref_load(rdata, p_type, p_lo);
               end
            end
         end else if (flush) nb = 2;
      end else if (rvalid) begin
         nb = 0;
      end
`ifdef WB_FWD_EN
      chk("fwd_valid", fwd_valid, e_rd != 0);
      chk("fwd_rd", fwd_rd, e_rd);
      chk("fwd_data", fwd_data, e_data);
`endif
      @(posedge clk);
      #1;
      busy = nb;
      chk("rd", o_rd, e_rd);
      chk("rd_data", o_data, e_data);
      chk("retire", retire, e_ret);
      chk("addr_err", addr_err, e_err);
   endtask

   task automatic alu_op(input logic en, input logic [4:0] r, input logic [31:0] v);
      idle_in(); valid = 1; wb_en = en; rd = r; alu = v;
      step();
   endtask

   // Issue a load, idle for gap cycles, then deliver read data
   task automatic load_op(input logic [4:0] r, input logic [2:0] t, input logic [1:0] a,
                          input int gap, input logic [31:0] d);
      idle_in(); valid = 1; wb_en = 1; is_load = 1; rd = r; ltype = t; lo = a;
      step();
      idle_in();
      for (int i = 0; i < gap; i++) step();
      rvalid = 1; rdata = d;
      step();
      idle_in();
   endtask

   initial begin
      idle_in();
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      busy = 0;
      chk("reset_rd", o_rd, 0);
      chk("reset_data", o_data, 0);
      chk("reset_retire", retire, 0);
      chk("reset_ready", ready, 1);
      idle_in();
      step();

      // ALU write, held exactly one cycle
      alu_op(1, 5'd5, 32'h1234_5678);
      chk("alu_rd", o_rd, 5);
      chk("alu_data", o_data, 32'h1234_5678);
      idle_in(); step();
      chk("alu_clear", o_data, 0);

      // Byte and halfword loads, including a misaligned halfword
      load_op(5'd3, 3'd3, 2'd3, 3, 32'h80FF_0000);
      chk("lb_data", o_data, 32'hFFFF_FF80);
      load_op(5'd3, 3'd4, 2'd3, 3, 32'h80FF_0000);
      chk("lbu_data", o_data, 32'h0000_0080);
      load_op(5'd4, 3'd1, 2'd2, 1, 32'h8001_1234);
      chk("lh_data", o_data, 32'hFFFF_8001);
      load_op(5'd4, 3'd1, 2'd1, 0, 32'h8001_1234);
      chk("lh_mis_err", addr_err, 1);
      chk("lh_mis_rd", o_rd, 0);

      // Flush one cycle after the load, data arrives later
      idle_in(); valid = 1; wb_en = 1; is_load = 1; rd = 9; step();
      idle_in(); step();
      flush = 1; step();
      idle_in(); step(); step();
      rvalid = 1; rdata = 32'hAAAA_5555; step();
      chk("drain_noretire", retire, 0);
      chk("drain_ready", ready, 1);
      // Flush together with rvalid
      idle_in(); valid = 1; wb_en = 1; is_load = 1; rd = 9; step();
      idle_in(); flush = 1; rvalid = 1; rdata = 32'h1; step();
      chk("flushrv_ready", ready, 1);

      // Suppressed writes still retire
      alu_op(1, 5'd0, 32'hDEAD_BEEF);
      chk("r0_retire", retire, 1);
      alu_op(0, 5'd7, 32'hDEAD_BEEF);
      chk("nowb_data", o_data, 0);

      // Reset while waiting for load data; the late rvalid is ignored
      idle_in(); valid = 1; wb_en = 1; is_load = 1; rd = 11; step();
      idle_in(); rst = 1; step();
      idle_in(); rvalid = 1; rdata = 32'h7777_7777; step();
      chk("rst_load_rd", o_rd, 0);
      chk("rst_load_ready", ready, 1);

      // Randomized traffic
      for (int c = 0; c < 3000; c++) begin
         idle_in();
         rst     = ($urandom_range(0, 99) < 2);
         valid   = $urandom_range(0, 1);
         wb_en   = ($urandom_range(0, 3) != 0);
         rd      = $urandom_range(0, 31);
         alu     = $urandom;
         is_load = ($urandom_range(0, 9) < 4);
         ltype   = $urandom_range(0, 7);
         lo      = $urandom_range(0, 3);
         flush   = ($urandom_range(0, 9) == 0);
         rvalid  = ($urandom_range(0, 9) < 3);
         rdata   = $urandom;
         step();
      end

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/wb_stage.md
Name: wb_stage

Overview:
- Writeback stage directly upstream of the general register file.
- Accepts retiring instructions from the MEM stage: ALU results or loads.
- Waits for variable-latency data-memory read data, then sign/zero-extends and byte-aligns it.
- Drives the register file write address and data for exactly one cycle per retired write.
- The register file writes on every clock edge and has no write enable. Every non-write cycle must therefore present o_rd=0 and o_rd_data=0, which keeps r0 at zero.

Parameters:
- DATA_W, 32, register/data width; must equal `REGISTER_WIDTH.
- RD_W, 5, destination register index width; must equal `RD_WIDTH.

Ports:
- i_clk  in  1  clock; one clock domain; all state updates on posedge.
- i_rst  in  1  reset; synchronous, active-high.
- i_valid  in  1  MEM stage presents an instruction.
- o_ready  out  1  stage can accept; transfer = i_valid & o_ready.
- i_wb_en  in  1  instruction writes a register.
- i_rd  in  RD_W  destination register.
- i_alu_result  in  DATA_W  result for non-loads.
- i_is_load  in  1  instruction is a load.
- i_load_type  in  3  000 LW, 001 LH, 010 LHU, 011 LB, 100 LBU; others treated as LW.
- i_addr_lo  in  2  load address bits [1:0].
- i_flush  in  1  squash in-flight instruction.
- i_dmem_rvalid  in  1  one-cycle pulse; read data valid.
- i_dmem_rdata  in  DATA_W  read word.
- o_rd  out  RD_W  register file write index.
- o_rd_data  out  DATA_W  register file write data.
- o_retire  out  1  pulse: instruction completed (written or no-write).
- o_addr_err  out  1  pulse: misaligned load suppressed.

Behaviour:
Reset:
- state=IDLE; o_rd=0, o_rd_data=0, o_retire=0, o_addr_err=0; o_ready=1 in the cycle after reset deasserts.
- Reset has priority over all inputs, including mid-load. A later stray rvalid in IDLE is ignored.

Outputs:
- o_rd, o_rd_data, o_retire and o_addr_err are registered. Each write is held exactly one cycle, then returns to 0.
- o_ready is combinational from state: 1 only in IDLE.

FSM states IDLE, WAIT_LOAD, DRAIN:
- IDLE, transfer, non-load: next cycle o_rd=i_rd, o_rd_data=i_alu_result, o_retire=1. Latency 1. Back-to-back transfers allowed every cycle.
- IDLE, transfer, load: latch rd, wb_en, load_type and addr_lo; go to WAIT_LOAD. rvalid in the transfer cycle is ignored, so the earliest usable rvalid is the following cycle.
- WAIT_LOAD, rvalid: align the data and drive o_rd/o_rd_data/o_retire the next cycle; go to IDLE. Aligned data is therefore registered one cycle after rvalid.
- WAIT_LOAD, i_flush, no rvalid: go to DRAIN; no write, no retire.
- WAIT_LOAD, i_flush and rvalid in the same cycle: discard the data; go to IDLE.
- DRAIN: o_ready=0; wait for rvalid, discard it, go to IDLE. Further flushes have no effect.
- IDLE, i_flush with i_valid: transfer is squashed, nothing latched, no retire.
- Flush never cancels an output already registered and being driven this cycle.

Write suppression:
- If wb_en=0 or rd=0: o_rd=0, o_rd_data=0, o_retire still pulses.

Load alignment (little-endian; lane = addr_lo):
- LB/LBU use byte lane addr_lo*8.
- LH/LHU use half addr_lo[1]*16.
- Sign-extend LB/LH; zero-extend LBU/LHU.
- Misalignment: LW with addr_lo≠0, or LH/LHU with addr_lo[0]=1. Detected at transfer; the load is still awaited. On completion: no write (o_rd=0), o_addr_err=1, o_retire=1.

Optional Feature:
- Macro WB_FWD_EN.
- Defined: adds combinational outputs o_fwd_valid (1), o_fwd_rd (RD_W), o_fwd_data (DATA_W).
  - These equal the values about to be registered into o_rd/o_rd_data, with valid=1 only when rd≠0 and the write is not suppressed.
  - Decode stage uses them to bypass the register file one cycle early.
- Undefined: ports absent; no added logic.

Test Plan:
- Reset, then ALU op rd=5, result 0x12345678 → next cycle o_rd=5, o_rd_data=0x12345678, o_retire=1; following cycle o_rd=0, o_rd_data=0.
- LB, addr_lo=3, rvalid 4 cycles later with rdata 0x80FF_0000 → o_ready=0 while waiting; cycle after rvalid o_rd_data=0xFFFFFF80. LBU same stimulus → 0x00000080.
- LH, addr_lo=2, rdata 0x8001_1234 → 0xFFFF8001. LH, addr_lo=1 → o_addr_err=1, o_rd=0, o_retire=1.
- Load issued, i_flush 1 cycle later, rvalid 3 cycles later → no write, no retire, o_ready=0 until the cycle after rvalid. Flush coincident with rvalid → immediate IDLE, no write.
- ALU writes rd=0 data 0xDEADBEEF, then wb_en=0 rd=7 → o_rd=0, o_rd_data=0 both cycles, two o_retire pulses.
- i_rst asserted in WAIT_LOAD, rvalid arrives after → no write, o_ready=1, outputs 0. With WB_FWD_EN: o_fwd_* match the next-cycle o_rd/o_rd_data.
